// File: rtl/clap_pkg.sv
// Shared encodings and helpers for the clap sequence detector.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package clap_pkg;

  // Detector FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HIGH    = 3'd1,
    CONFIRM = 3'd2,
    EMIT    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Energy level of one sample
  typedef enum logic [1:0] {
    LVL_LOW  = 2'd0,
    LVL_MID  = 2'd1,
    LVL_HIGH = 2'd2
  } level_t;

  // Bits needed to hold values 0 .. value-1
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clap_sequence_detector_if.sv
// Energy-in / event-out bundle of the clap sequence detector, plus its configuration.
// Latency: none (wiring only).
// Backpressure: energy side and event side each use valid/ready.
interface clap_sequence_detector_if
  import clap_pkg::*;
#(
  parameter int ENERGY_WIDTH = 16,
  parameter int COUNT_WIDTH  = 8,
  parameter int GAP_WIDTH    = 16,
  parameter int CLAPS_MAX    = 4,
  parameter int CW           = clogb2(CLAPS_MAX + 1)
);
  logic [ENERGY_WIDTH-1:0] energy_data;
  logic                    energy_valid;
  logic                    energy_ready;
  logic [ENERGY_WIDTH-1:0] k_low;
  logic [ENERGY_WIDTH-1:0] k_high;
  logic [COUNT_WIDTH-1:0]  n_high_min;
  logic [COUNT_WIDTH-1:0]  n_high_max;
  logic [COUNT_WIDTH-1:0]  n_low_min;
  logic [GAP_WIDTH-1:0]    gap_max;
  logic [CW-1:0]           clap_target;
  logic                    clap_valid;
  logic                    clap_ready;
  logic [CW-1:0]           clap_count;
  logic [CW-1:0]           claps_seen;

  // Producer of samples/config and consumer of events
  modport master (
    output energy_data, energy_valid, k_low, k_high, n_high_min, n_high_max,
           n_low_min, gap_max, clap_target, clap_ready,
    input  energy_ready, clap_valid, clap_count, claps_seen
  );

  // The detector itself
  modport slave (
    input  energy_data, energy_valid, k_low, k_high, n_high_min, n_high_max,
           n_low_min, gap_max, clap_target, clap_ready,
    output energy_ready, clap_valid, clap_count, claps_seen
  );
endinterface

// File: rtl/clap_level_classifier.sv
// Classifies one energy sample as LOW (< k_low), HIGH (> k_high) or MID.
// Latency: combinational.
// Backpressure: none; purely a function of its inputs.
module clap_level_classifier
  import clap_pkg::*;
#(
  parameter int ENERGY_WIDTH = 16
) (
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic [ENERGY_WIDTH-1:0] k_low,
  input  logic [ENERGY_WIDTH-1:0] k_high,
  output level_t                  level
);

  // Threshold compare; samples equal to either threshold are MID
  always_comb begin
    level = LVL_MID;
    if (energy_data < k_low) begin
      level = LVL_LOW;
    end else if (energy_data > k_high) begin
      level = LVL_HIGH;
    end
  end

endmodule

// File: rtl/clap_sequence_detector.sv
// Recognises claps from HIGH/LOW run lengths and emits one event per N claps within a gap window.
// Latency: clap_valid rises the cycle after the final confirming LOW sample is accepted.
// Backpressure: while an event waits for clap_ready, energy_ready is low and no samples are taken.
module clap_sequence_detector
  import clap_pkg::*;
#(
  parameter int ENERGY_WIDTH = 16,
  parameter int COUNT_WIDTH  = 8,
  parameter int GAP_WIDTH    = 16,
  parameter int CLAPS_MAX    = 4
) (
  input logic clock,
  input logic nreset,
  clap_sequence_detector_if.slave bus
);

  localparam int CW = clogb2(CLAPS_MAX + 1);
  localparam logic [CW-1:0]          TARGET_MAX = CW'(CLAPS_MAX);
  localparam logic [CW-1:0]          TARGET_ONE = CW'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] high_cnt;
  logic [COUNT_WIDTH-1:0] low_cnt;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [CW-1:0]          claps_seen_q;
  logic [CW-1:0]          clap_count_q;
  logic                   clap_valid_q;
  logic                   energy_ready_q;

  level_t                 level;
  logic                   accept;
  logic [COUNT_WIDTH-1:0] high_inc;
  logic [COUNT_WIDTH-1:0] low_inc;
  logic [GAP_WIDTH-1:0]   gap_inc;
  logic                   timeout;
  logic                   recog;
  logic [CW-1:0]          seen_inc;
  logic [CW-1:0]          eff_target;

  clap_level_classifier #(
    .ENERGY_WIDTH(ENERGY_WIDTH)
  ) u_classifier (
    .energy_data(bus.energy_data),
    .k_low      (bus.k_low),
    .k_high     (bus.k_high),
    .level      (level)
  );

  // Saturating increments, effective target and clap recognition for the current sample
  always_comb begin
    accept     = bus.energy_valid && energy_ready_q;
    high_inc   = (high_cnt == '1) ? high_cnt : high_cnt + 1'b1;
    low_inc    = (low_cnt == '1) ? low_cnt : low_cnt + 1'b1;
    gap_inc    = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
    timeout    = (gap_inc >= bus.gap_max);
    seen_inc   = claps_seen_q + 1'b1;
    eff_target = bus.clap_target;
    if (bus.clap_target == '0) begin
      eff_target = TARGET_ONE;
    end else if (bus.clap_target > TARGET_MAX) begin
      eff_target = TARGET_MAX;
    end
    recog = 1'b0;
    if (accept && level == LVL_LOW) begin
      if (state == HIGH && high_cnt >= bus.n_high_min && bus.n_low_min <= COUNT_ONE) begin
        recog = 1'b1;
      end else if (state == CONFIRM && low_inc >= bus.n_low_min) begin
        recog = 1'b1;
      end
    end
  end

  // Detector FSM with run-length, gap and clap counters; later assignments take priority
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      high_cnt       <= '0;
      low_cnt        <= '0;
      gap_cnt        <= '0;
      claps_seen_q   <= '0;
      clap_count_q   <= '0;
      clap_valid_q   <= 1'b0;
      energy_ready_q <= 1'b0;
    end else if (state == EMIT) begin
      if (bus.clap_ready) begin
        clap_valid_q   <= 1'b0;
        claps_seen_q   <= '0;
        gap_cnt        <= '0;
        energy_ready_q <= 1'b1;
        state          <= IDLE;
      end
    end else begin
      energy_ready_q <= 1'b1;
      if (accept) begin
        // Gap window runs only while a sequence is open; LOCKOUT freezes it
        if (claps_seen_q != '0 && state != LOCKOUT) begin
          if (timeout) begin
            claps_seen_q <= '0;
            gap_cnt      <= '0;
          end else begin
            gap_cnt <= gap_inc;
          end
        end
        unique case (state)
          IDLE: begin
            if (level == LVL_HIGH) begin
              state    <= HIGH;
              high_cnt <= COUNT_ONE;
            end
          end
          HIGH: begin
            if (level == LVL_HIGH) begin
              high_cnt <= high_inc;
              if (high_inc > bus.n_high_max) begin
                // Too long to be a clap: treat as sustained noise
                state        <= LOCKOUT;
                claps_seen_q <= '0;
                gap_cnt      <= '0;
              end
            end else if (level == LVL_MID || high_cnt < bus.n_high_min) begin
              state <= IDLE;
            end else begin
              state   <= CONFIRM;
              low_cnt <= COUNT_ONE;
            end
          end
          CONFIRM: begin
            if (level == LVL_LOW) begin
              low_cnt <= low_inc;
            end else if (level == LVL_MID) begin
              state <= IDLE;
            end else begin
              state    <= HIGH;
              high_cnt <= COUNT_ONE;
            end
          end
          LOCKOUT: begin
            if (level == LVL_LOW) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // Recognition overrides both the FSM move and a coincident timeout
        if (recog) begin
          claps_seen_q <= seen_inc;
          gap_cnt      <= '0;
          if (seen_inc == eff_target) begin
            state          <= EMIT;
            clap_valid_q   <= 1'b1;
            clap_count_q   <= seen_inc;
            energy_ready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

  assign bus.energy_ready = energy_ready_q;
  assign bus.clap_valid   = clap_valid_q;
  assign bus.clap_count   = clap_count_q;
  assign bus.claps_seen   = claps_seen_q;

endmodule

// File: tb/tb_clap_sequence_detector.sv
// Self-checking bench: scripted scenarios plus randomized sample streams against a run-length model.
// Latency: outputs are compared at the falling edge after each driven cycle.
// Backpressure: clap_ready is held low and randomized to stall the event side.
module tb_clap_sequence_detector;

  localparam int HI  = 200;
  localparam int LO  = 10;
  localparam int MID = 48;

  logic clock;
  logic nreset;

  clap_sequence_detector_if bus ();

  clap_sequence_detector dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors;
  int checks;

  // Configuration mirrored for the model
  int c_klow, c_khigh, c_nhmin, c_nhmax, c_nlmin, c_gapmax, c_target;

  // Reference model: candidate HIGH-run length, confirming LOW count, lockout flag,
  // open-sequence clap count and gap, pending event, and the ready the DUT should show.
  int m_high, m_low, m_claps, m_gap, m_count;
  bit m_lock, m_pending, m_ready;

  function automatic int eff_target();
    if (c_target == 0) return 1;
    if (c_target > 4) return 4;
    return c_target;
  endfunction

  task automatic model_reset();
    m_high = 0; m_low = 0; m_claps = 0; m_gap = 0; m_count = 0;
    m_lock = 0; m_pending = 0; m_ready = 0;
  endtask

  task automatic model_accept(input int d);
    int  lv;
    bit  tmo;
    bit  rec;
    lv  = (d < c_klow) ? 0 : ((d > c_khigh) ? 2 : 1);
    tmo = 0;
    rec = 0;
    if (m_lock) begin
      if (lv == 0) m_lock = 0;
      return;
    end
    if (m_claps > 0) begin
      m_gap++;
      if (m_gap >= c_gapmax) tmo = 1;
    end
    if (lv == 2) begin
      if (m_high > 0 && m_low == 0) begin
        m_high++;
        if (m_high > c_nhmax) begin
          m_lock = 1; m_claps = 0; m_gap = 0; m_high = 0;
          return;
        end
      end else begin
        m_high = 1; m_low = 0;
      end
    end else if (lv == 1) begin
      m_high = 0; m_low = 0;
    end else begin
      if (m_low > 0) m_low++;
      else if (m_high > 0) begin
        if (m_high >= c_nhmin) m_low = 1;
        else m_high = 0;
      end
      if (m_low > 0 && m_low >= c_nlmin) begin
        rec = 1; m_high = 0; m_low = 0;
      end
    end
    if (rec) begin
      m_claps++;
      m_gap = 0;
      if (m_claps == eff_target()) begin
        m_pending = 1;
        m_count   = m_claps;
      end
    end else if (tmo) begin
      m_claps = 0; m_gap = 0;
    end
  endtask

  // One clock of stimulus; starts and ends at a falling edge
  task automatic drive(input bit v, input int d, input bit r);
    bit acc;
    bus.energy_valid = v;
    bus.energy_data  = 16'(d);
    bus.clap_ready   = r;
    @(posedge clock);
    acc = v && m_ready;
    if (m_pending) begin
      if (r) begin
        m_pending = 0; m_claps = 0; m_gap = 0;
      end
    end else if (acc) begin
      model_accept(d);
    end
    m_ready = !m_pending;
    @(negedge clock);
  endtask

  task automatic run(input int n, input int d, input bit r);
    repeat (n) drive(1'b1, d, r);
  endtask

  task automatic set_cfg(input int kl, input int kh, input int hmin, input int hmax,
                         input int lmin, input int gmax, input int tgt);
    c_klow = kl; c_khigh = kh; c_nhmin = hmin; c_nhmax = hmax;
    c_nlmin = lmin; c_gapmax = gmax; c_target = tgt;
    bus.k_low       = 16'(kl);
    bus.k_high      = 16'(kh);
    bus.n_high_min  = 8'(hmin);
    bus.n_high_max  = 8'(hmax);
    bus.n_low_min   = 8'(lmin);
    bus.gap_max     = 16'(gmax);
    bus.clap_target = 3'(tgt);
  endtask

  task automatic apply_reset(input int tgt, input int lmin);
    @(negedge clock);
    nreset = 1'b0;
    bus.energy_valid = 1'b0;
    bus.clap_ready   = 1'b0;
    set_cfg(32, 64, 2, 8, lmin, 100, tgt);
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.energy_valid = 1'b1;
    bus.energy_data  = 16'(HI);
    bus.clap_ready   = 1'b1;
    set_cfg(32, 64, 2, 8, 4, 100, 2);
    model_reset();
    #12;
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.clap_count !== 3'd0 || bus.claps_seen !== 3'd0 || bus.energy_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b count=%0d seen=%0d ready=%b, required all 0",
               bus.clap_valid, bus.clap_count, bus.claps_seen, bus.energy_ready);
    end
    @(negedge clock);
    nreset = 1'b1;
    drive(1'b0, 0, 1'b0);
    checks++;
    if (bus.energy_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_up: energy_ready=%b, required 1", bus.energy_ready);
    end
  endtask

  task automatic test_two_claps();
    apply_reset(2, 4);
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1 || bus.clap_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_claps_first: seen=%0d valid=%b, required 1 0", bus.claps_seen, bus.clap_valid);
    end
    run(20, LO, 1'b1); run(3, HI, 1'b1); run(3, LO, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_claps_early: clap_valid=%b, required 0", bus.clap_valid);
    end
    run(1, LO, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b1 || bus.clap_count !== 3'd2 || bus.energy_ready !== 1'b0) begin
      errors++;
      $display("FAIL two_claps_event: valid=%b count=%0d ready=%b, required 1 2 0",
               bus.clap_valid, bus.clap_count, bus.energy_ready);
    end
    drive(1'b0, 0, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL two_claps_handshake: valid=%b seen=%0d, required 0 0", bus.clap_valid, bus.claps_seen);
    end
  endtask

  task automatic test_gap_timeout();
    apply_reset(2, 4);
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    run(99, MID, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1) begin
      errors++;
      $display("FAIL gap_before_limit: claps_seen=%0d, required 1", bus.claps_seen);
    end
    run(1, MID, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL gap_at_limit: claps_seen=%0d, required 0", bus.claps_seen);
    end
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1 || bus.clap_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_restart: seen=%0d valid=%b, required 1 0", bus.claps_seen, bus.clap_valid);
    end
  endtask

  task automatic test_windows();
    apply_reset(2, 4);
    run(1, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL window_short: claps_seen=%0d, required 0", bus.claps_seen);
    end
    run(2, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1) begin
      errors++;
      $display("FAIL window_min_run: claps_seen=%0d, required 1", bus.claps_seen);
    end
    run(8, HI, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1) begin
      errors++;
      $display("FAIL window_max_run: claps_seen=%0d, required 1", bus.claps_seen);
    end
    run(1, HI, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL window_lockout: claps_seen=%0d, required 0", bus.claps_seen);
    end
    run(2, MID, 1'b1); run(3, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL window_lockout_hold: claps_seen=%0d, required 0", bus.claps_seen);
    end
    run(8, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1) begin
      errors++;
      $display("FAIL window_lockout_exit: claps_seen=%0d, required 1", bus.claps_seen);
    end
    run(3, HI, 1'b1); run(1, MID, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1 || bus.clap_valid !== 1'b0) begin
      errors++;
      $display("FAIL window_mid_discard: seen=%0d valid=%b, required 1 0", bus.claps_seen, bus.clap_valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset(2, 4);
    run(3, HI, 1'b0); run(4, LO, 1'b0);
    run(3, HI, 1'b0); run(4, LO, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, HI, 1'b0);
      checks++;
      if (bus.energy_ready !== 1'b0 || bus.clap_valid !== 1'b1 || bus.clap_count !== 3'd2) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b count=%0d, required 0 1 2",
                 i, bus.energy_ready, bus.clap_valid, bus.clap_count);
      end
    end
    drive(1'b0, 0, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.energy_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", bus.clap_valid, bus.energy_ready);
    end
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.claps_seen !== 3'd1) begin
      errors++;
      $display("FAIL backpressure_resume: claps_seen=%0d, required 1", bus.claps_seen);
    end
  endtask

  task automatic test_target_bounds();
    apply_reset(0, 4);
    for (int i = 0; i < 2; i++) begin
      run(3, HI, 1'b1); run(4, LO, 1'b1);
      checks++;
      if (bus.clap_valid !== 1'b1 || bus.clap_count !== 3'd1) begin
        errors++;
        $display("FAIL target_zero[%0d]: valid=%b count=%0d, required 1 1", i, bus.clap_valid, bus.clap_count);
      end
      drive(1'b0, 0, 1'b1);
    end
    apply_reset(7, 4);
    for (int i = 0; i < 3; i++) begin
      run(3, HI, 1'b1); run(4, LO, 1'b1);
    end
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.claps_seen !== 3'd3) begin
      errors++;
      $display("FAIL target_clamp_pre: valid=%b seen=%0d, required 0 3", bus.clap_valid, bus.claps_seen);
    end
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b1 || bus.clap_count !== 3'd4) begin
      errors++;
      $display("FAIL target_clamp_event: valid=%b count=%0d, required 1 4", bus.clap_valid, bus.clap_count);
    end
    drive(1'b0, 0, 1'b1);
  endtask

  task automatic test_low_min_one();
    apply_reset(1, 1);
    run(3, HI, 1'b0);
    run(1, LO, 1'b0);
    checks++;
    if (bus.clap_valid !== 1'b1 || bus.clap_count !== 3'd1) begin
      errors++;
      $display("FAIL low_min_one: valid=%b count=%0d, required 1 1", bus.clap_valid, bus.clap_count);
    end
    drive(1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    apply_reset(2, 4);
    run(3, HI, 1'b1); run(4, LO, 1'b1);
    run(3, HI, 1'b1); run(2, LO, 1'b1);
    #3 nreset = 1'b0;
    #1;
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.claps_seen !== 3'd0 || bus.energy_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_confirm: valid=%b seen=%0d ready=%b, required 0 0 0",
               bus.clap_valid, bus.claps_seen, bus.energy_ready);
    end
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    run(6, LO, 1'b1);
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.claps_seen !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_after: valid=%b seen=%0d, required 0 0", bus.clap_valid, bus.claps_seen);
    end
    apply_reset(1, 4);
    run(3, HI, 1'b0); run(4, LO, 1'b0);
    #3 nreset = 1'b0;
    #1;
    checks++;
    if (bus.clap_valid !== 1'b0 || bus.clap_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_event: valid=%b count=%0d, required 0 0", bus.clap_valid, bus.clap_count);
    end
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic test_random();
    int lv, left, d, hit;
    bit v, r;
    hit = 0;
    for (int seg = 0; seg < 4; seg++) begin
      apply_reset(1 + seg, 3);
      set_cfg(32, 64, 2, 6, 3, 30, 1 + seg);
      lv   = 0;
      left = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
        if (left == 0) begin
          lv   = $urandom_range(0, 2);
          left = $urandom_range(1, 7);
        end
        case (lv)
          0:       d = $urandom_range(0, 31);
          1:       d = $urandom_range(32, 64);
          default: d = $urandom_range(65, 400);
        endcase
        v = ($urandom_range(0, 4) != 0);
        r = ($urandom_range(0, 2) != 0);
        if (v && m_ready) left--;
        drive(v, d, r);
        if (m_pending) hit++;
        checks++;
        if (bus.energy_ready !== m_ready || bus.clap_valid !== m_pending ||
            int'(bus.claps_seen) !== m_claps || int'(bus.clap_count) !== m_count) begin
          errors++;
          $display("FAIL random[%0d.%0d]: ready=%b valid=%b seen=%0d count=%0d, required %b %b %0d %0d",
                   seg, cyc, bus.energy_ready, bus.clap_valid, bus.claps_seen, bus.clap_count,
                   m_ready, m_pending, m_claps, m_count);
        end
      end
    end
    checks++;
    if (hit == 0) begin
      errors++;
      $display("FAIL random_events: cycles with an event=%0d, required >0", hit);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.energy_valid = 1'b0;
    bus.energy_data  = '0;
    bus.clap_ready   = 1'b0;
    test_reset();
    test_two_claps();
    test_gap_timeout();
    test_windows();
    test_backpressure();
    test_target_bounds();
    test_low_min_one();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clap_sequence_detector.md
Name: clap_sequence_detector

Overview:
- Successor to the single-clap detector. Consumes the per-frame energy stream, classifies each sample as LOW, MID or HIGH, and recognises claps from run-lengths within runtime windows.
- Counts consecutive claps and emits one event when a programmable clap count is reached inside a gap timeout.
- Sits between the energy estimator and the light-control logic; both sides use valid/ready handshakes.

Parameters:
- ENERGY_WIDTH, 16: energy sample width.
- COUNT_WIDTH, 8: width of the run-length counters and their thresholds.
- GAP_WIDTH, 16: width of the inter-clap gap counter and `gap_max`.
- CLAPS_MAX, 4: maximum programmable clap count. CW = clogb2(CLAPS_MAX+1).

Ports:
- clock  in  1  sole clock.
- nreset  in  1  asynchronous active-low reset.
- energy_data  in  ENERGY_WIDTH  energy sample.
- energy_valid  in  1  sample valid.
- energy_ready  out  1  sample accepted when valid & ready.
- k_low  in  ENERGY_WIDTH  LOW threshold: sample < k_low.
- k_high  in  ENERGY_WIDTH  HIGH threshold: sample > k_high. Any other sample is MID.
- n_high_min  in  COUNT_WIDTH  minimum HIGH run length.
- n_high_max  in  COUNT_WIDTH  maximum HIGH run length.
- n_low_min  in  COUNT_WIDTH  LOW samples required to confirm a clap.
- gap_max  in  GAP_WIDTH  accepted samples allowed between claps.
- clap_target  in  CW  claps per event. 0 is treated as 1; values >CLAPS_MAX are clamped to CLAPS_MAX.
- clap_valid  out  1  sequence event valid.
- clap_ready  in  1  event consumer ready.
- clap_count  out  CW  claps in the event; held stable while clap_valid is high.
- claps_seen  out  CW  live count of claps in the current sequence (status).

Behaviour:
- Reset: clock and reset are fixed as above (one clock `clock`; `nreset` asynchronous, active-low). On reset, all outputs are 0 and state is IDLE. Reset mid-sequence or mid-event drops everything; no event is emitted afterwards.
- energy_ready: equals !clap_valid, driven from registers. At most one sample is accepted per cycle. Only accepted samples advance any counter.
- Configuration inputs are quasi-static; they are sampled each accepted cycle and must be changed only while claps_seen==0.
- Run-length counters saturate at 2^COUNT_WIDTH-1.
- State IDLE:
  - HIGH sample -> HIGH, high_cnt=1.
  - LOW or MID sample -> stay.
- State HIGH:
  - HIGH sample -> high_cnt+1. If the result exceeds n_high_max -> LOCKOUT and claps_seen=0 (sustained noise).
  - MID sample -> IDLE; candidate discarded.
  - LOW sample with high_cnt < n_high_min -> IDLE; candidate discarded.
  - LOW sample with high_cnt >= n_high_min -> CONFIRM, low_cnt=1. If n_low_min<=1, the clap is recognised on this same sample.
- State CONFIRM:
  - LOW sample -> low_cnt+1. Reaching n_low_min means the clap is recognised.
  - MID sample -> IDLE; candidate discarded.
  - HIGH sample -> HIGH, high_cnt=1 (new candidate).
- Clap recognised:
  - claps_seen+1, gap_cnt=0.
  - If the new count equals the effective target -> EMIT: clap_valid=1, clap_count=new count. Otherwise -> IDLE.
- State EMIT: clap_valid stays high until clap_ready. In that handshake cycle: clap_valid=0, claps_seen=0, gap_cnt=0, -> IDLE. No samples are accepted while in EMIT.
- State LOCKOUT: stay until a LOW sample, then -> IDLE. Gap counter is frozen.
- Gap timeout:
  - While claps_seen>0 and not in EMIT, gap_cnt increments on every accepted sample (saturating).
  - When gap_cnt reaches gap_max: claps_seen=0, gap_cnt=0, state unchanged, so an in-flight candidate can still become clap 1.
  - If a clap recognition and the timeout fall on the same sample, the recognition wins.
- Latency: clap_valid rises the cycle after acceptance of the final confirming LOW sample.

Decomposition:
- Package clap_pkg holds:
  - state encoding: IDLE, HIGH, CONFIRM, EMIT, LOCKOUT;
  - level encoding: LVL_LOW, LVL_MID, LVL_HIGH;
  - clogb2 function.
- Sub-module clap_level_classifier: combinational comparison of energy_data against k_low/k_high, producing a 2-bit level. Detector FSM and counters form the top module.

Test Plan:
- Common config: k_low=32, k_high=64, n_high 2..8, n_low_min=4, clap_target=2, gap_max=100.
- Two claps: [200×3, 10×4, 10×20, 200×3, 10×4] -> clap_valid one cycle after the final LOW sample, clap_count=2, claps_seen returns to 0 after the handshake.
- Gap timeout: one clap, then 100 MID samples, then one clap -> no event; claps_seen reads 1, then 0, then 1.
- Length windows: 200×1 then LOW×4 -> no clap (too short). 200×9 -> LOCKOUT and claps_seen=0; LOCKOUT is exited only after a LOW sample. A MID sample (48) between HIGH and LOW discards the candidate.
- Backpressure: hold clap_ready=0 for 10 cycles during EMIT -> energy_ready=0 and clap_valid/clap_count stable throughout; no samples lost after release.
- Boundary: clap_target=0 -> an event fires on every clap. n_low_min=1 -> a clap is recognised on the first LOW sample. Assert nreset mid-CONFIRM -> all outputs 0 immediately and no later event.
